// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction phase timer.
package traffic_pkg;

  localparam int unsigned LANE_W  = 2;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned DENS_W  = 2 * N_LANES;
  localparam int unsigned BCD_W   = 8;

  typedef enum logic {
    GREEN  = 1'b0,
    YELLOW = 1'b1
  } phase_e;

  localparam logic [1:0] D_NONE = 2'd0;
  localparam logic [1:0] D_LOW  = 2'd1;
  localparam logic [1:0] D_MED  = 2'd2;
  localparam logic [1:0] D_HIGH = 2'd3;

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Sensor input and lamp/display outputs of the junction controller.
interface traffic_phase_timer_if;
  import traffic_pkg::*;

  logic [DENS_W-1:0]  density;
  logic [LANE_W-1:0]  lane_state;
  logic [BCD_W-1:0]   time_bcd;
  logic [N_LANES-1:0] green;
  logic [N_LANES-1:0] yellow;
  logic [N_LANES-1:0] red;
  logic               phase_done;

  // master: the controller; slave: sensors feeding it and the display/lamps it drives
  modport master (
    input  density,
    output lane_state, time_bcd, green, yellow, red, phase_done
  );

  modport slave (
    output density,
    input  lane_state, time_bcd, green, yellow, red, phase_done
  );
endinterface

// File: rtl/traffic_phase_timer_bcd_down2.sv
// Two-digit BCD down-counter with load, decrement enable and an is-one flag.
module bcd_down2
  import traffic_pkg::*;
#(
  parameter logic [BCD_W-1:0] RST_VAL = 8'h10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [BCD_W-1:0] o_val,
  output logic             o_is_one_c
);

  logic [BCD_W-1:0] r_val;
  logic [BCD_W-1:0] w_dec_val;

  // Units at zero wrap to nine and borrow one from the tens digit
  always_comb begin
    w_dec_val = r_val;
    if (r_val[3:0] == 4'd0) begin
      w_dec_val[3:0] = 4'd9;
      w_dec_val[7:4] = r_val[7:4] - 4'd1;
    end else begin
      w_dec_val[3:0] = r_val[3:0] - 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_val <= RST_VAL;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_dec) begin
      r_val <= w_dec_val;
    end
  end

  assign o_val      = r_val;
  assign o_is_one_c = (r_val == 8'h01);

endmodule

// File: rtl/traffic_phase_timer.sv
// Density-driven green/yellow phase sequencer with BCD countdown for a 4-way junction.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned      TICK_DIV   = 1000,
  parameter logic [BCD_W-1:0] GREEN_LOW  = 8'h10,
  parameter logic [BCD_W-1:0] GREEN_MED  = 8'h20,
  parameter logic [BCD_W-1:0] GREEN_HIGH = 8'h30,
  parameter logic [BCD_W-1:0] YELLOW_T   = 8'h03
) (
  input  logic                  clk_slow,
  input  logic                  reset,
  traffic_phase_timer_if.master bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DENS_W-1:0]  r_dens_meta;
  logic [DENS_W-1:0]  r_dens_s;
  logic [PW-1:0]      r_presc;
  phase_e             r_phase;
  logic [LANE_W-1:0]  r_lane;
  logic               r_phase_done;

  logic               w_tick;
  logic               w_is_one;
  logic               w_phase_end;
  logic [LANE_W-1:0]  w_next_lane;
  logic [BCD_W-1:0]   w_load_val;
  logic [BCD_W-1:0]   w_time;
  logic [N_LANES-1:0] w_lane_oh;

  // First non-empty lane after the current one; plain rotation if all others are empty
  function automatic logic [LANE_W-1:0] next_lane(input logic [DENS_W-1:0] dens,
                                                  input logic [LANE_W-1:0] lane);
    logic [LANE_W-1:0] idx;
    logic              found;
    next_lane = lane + LANE_W'(1);
    found     = 1'b0;
    for (int unsigned k = 1; k < N_LANES; k++) begin
      idx = lane + LANE_W'(k);
      if (!found && (dens[2*idx +: 2] != D_NONE)) begin
        next_lane = idx;
        found     = 1'b1;
      end
    end
  endfunction

  function automatic logic [BCD_W-1:0] green_time(input logic [1:0] level);
    case (level)
      D_MED:   green_time = GREEN_MED;
      D_HIGH:  green_time = GREEN_HIGH;
      default: green_time = GREEN_LOW;
    endcase
  endfunction

  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      r_dens_meta <= '0;
      r_dens_s    <= '0;
    end else begin
      r_dens_meta <= bus.density;
      r_dens_s    <= r_dens_meta;
    end
  end

  // Free-running second prescaler, deliberately not realigned on phase changes
  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_phase_end = w_tick && w_is_one;
  assign w_next_lane = next_lane(r_dens_s, r_lane);
  assign w_load_val  = (r_phase == GREEN) ? YELLOW_T
                                          : green_time(r_dens_s[2*w_next_lane +: 2]);

  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      r_phase      <= GREEN;
      r_lane       <= '0;
      r_phase_done <= 1'b0;
    end else begin
      r_phase_done <= w_phase_end;
      if (w_phase_end) begin
        if (r_phase == GREEN) begin
          r_phase <= YELLOW;
        end else begin
          r_phase <= GREEN;
          r_lane  <= w_next_lane;
        end
      end
    end
  end

  bcd_down2 #(
    .RST_VAL (GREEN_LOW)
  ) u_count (
    .i_clk      (clk_slow),
    .i_reset    (reset),
    .i_load     (w_phase_end),
    .i_load_val (w_load_val),
    .i_dec      (w_tick && !w_is_one),
    .o_val      (w_time),
    .o_is_one_c (w_is_one)
  );

  // Lamps derive only from registered phase and lane, so sensor noise cannot reach them
  assign w_lane_oh      = N_LANES'(1) << r_lane;
  assign bus.green      = (r_phase == GREEN)  ? w_lane_oh : '0;
  assign bus.yellow     = (r_phase == YELLOW) ? w_lane_oh : '0;
  assign bus.red        = ~(bus.green | bus.yellow);
  assign bus.lane_state = r_lane;
  assign bus.time_bcd   = w_time;
  assign bus.phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomised and directed checks of traffic_phase_timer against an integer-seconds reference model.
module tb_traffic_phase_timer;

  localparam int TD = 4;
  localparam logic [22:0] RST_VEC = {2'd0, 8'h10, 4'b0001, 4'b0000, 4'b1110, 1'b0};

  logic clk_slow = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  traffic_phase_timer_if tif ();

  traffic_phase_timer #(
    .TICK_DIV   (TD),
    .GREEN_LOW  (8'h10),
    .GREEN_MED  (8'h20),
    .GREEN_HIGH (8'h30),
    .YELLOW_T   (8'h03)
  ) dut (
    .clk_slow (clk_slow),
    .reset    (reset),
    .bus      (tif.master)
  );

  always #5 clk_slow = ~clk_slow;

  // Reference model: seconds as plain integers, synchroniser as a two-entry history
  int         m_lane, m_rem, m_cnt;
  bit         m_yel, m_done;
  logic [7:0] m_s1, m_s2;

  function automatic int lvl(input logic [7:0] d, input int l);
    return int'(d[2*l +: 2]);
  endfunction

  function automatic int green_secs(input int level);
    return (level <= 1) ? 10 : (level == 2) ? 20 : 30;
  endfunction

  task automatic m_reset();
    m_lane = 0; m_rem = 10; m_cnt = 0; m_yel = 0; m_done = 0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_edge();
    int nl;
    if (reset) begin
      m_reset();
      return;
    end
    m_done = 0;
    if (m_cnt == TD - 1) begin
      if (m_rem == 1) begin
        m_done = 1;
        if (!m_yel) begin
          m_yel = 1; m_rem = 3;
        end else begin
          nl = (m_lane + 1) % 4;
          for (int k = 3; k >= 1; k--)
            if (lvl(m_s2, (m_lane + k) % 4) != 0) nl = (m_lane + k) % 4;
          m_lane = nl; m_yel = 0; m_rem = green_secs(lvl(m_s2, nl));
        end
      end else begin
        m_rem--;
      end
    end
    m_cnt = (m_cnt + 1) % TD;
    m_s2  = m_s1;
    m_s1  = tif.density;
  endtask

  function automatic logic [22:0] exp_vec();
    logic [3:0] oh, g, y;
    oh = 4'b0001 << m_lane;
    g  = m_yel ? 4'b0000 : oh;
    y  = m_yel ? oh : 4'b0000;
    return {2'(m_lane), 4'(m_rem / 10), 4'(m_rem % 10), g, y, ~(g | y), m_done};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {tif.lane_state, tif.time_bcd, tif.green, tif.yellow, tif.red, tif.phase_done};
  endfunction

  task automatic step();
    @(posedge clk_slow);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tif.density = 8'hFF;
    do_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs_vec(), RST_VEC);
    end
    step();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", obs_vec(), exp_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_full_density();
    bit found = 0;
    tif.density = 8'hFF;
    do_reset();
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_density c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_done && !m_yel) found = 1;
    end
    checks++;
    if (!found || {tif.lane_state, tif.time_bcd} !== {2'd1, 8'h30}) begin
      errors++;
      $display("FAIL full_density_lane1 found=%0d got=%h exp=%h", found,
               {tif.lane_state, tif.time_bcd}, {2'd1, 8'h30});
    end
  endtask

  task automatic test_bcd_borrow();
    logic [7:0] prev;
    bit seen20 = 0, seen10 = 0;
    tif.density = 8'hAA;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      prev = tif.time_bcd;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bcd_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (tif.time_bcd[3:0] > 4'd9 || tif.time_bcd === 8'h00) begin
        errors++; $display("FAIL bcd_legal got=%h exp=legal_nonzero", tif.time_bcd);
      end
      if (prev == 8'h20 && tif.time_bcd != prev) begin
        seen20 = 1; checks++;
        if (tif.time_bcd !== 8'h19) begin
          errors++; $display("FAIL borrow_20 got=%h exp=19", tif.time_bcd);
        end
      end
      if (prev == 8'h10 && tif.time_bcd != prev) begin
        seen10 = 1; checks++;
        if (tif.time_bcd !== 8'h09) begin
          errors++; $display("FAIL borrow_10 got=%h exp=09", tif.time_bcd);
        end
      end
    end
    checks++;
    if (!(seen20 && seen10)) begin
      errors++; $display("FAIL borrow_seen got=%0d%0d exp=11", seen20, seen10);
    end
  endtask

  task automatic test_skip();
    logic [9:0] cap[$];
    tif.density = 8'b01_00_00_10;
    do_reset();
    for (int c = 0; c < 400 && cap.size() < 2; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL skip c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_done && !m_yel) cap.push_back({tif.lane_state, tif.time_bcd});
    end
    checks++;
    if (cap.size() != 2 || cap[0] !== {2'd3, 8'h10} || cap[1] !== {2'd0, 8'h20}) begin
      errors++;
      $display("FAIL skip_order n=%0d got=%h,%h exp=310,020", cap.size(),
               (cap.size() > 0) ? cap[0] : 10'h0, (cap.size() > 1) ? cap[1] : 10'h0);
    end
  endtask

  task automatic test_all_empty();
    logic [9:0] cap[$];
    int dut_done = 0, ends = 0;
    logic [9:0] want[4] = '{{2'd1, 8'h10}, {2'd2, 8'h10}, {2'd3, 8'h10}, {2'd0, 8'h10}};
    tif.density = 8'h00;
    do_reset();
    for (int c = 0; c < 500 && ends < 8; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL empty c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (tif.phase_done === 1'b1) dut_done++;
      if (m_done) ends++;
      if (m_done && !m_yel) cap.push_back({tif.lane_state, tif.time_bcd});
    end
    checks++;
    if (dut_done != 8) begin
      errors++; $display("FAIL empty_done_count got=%0d exp=8", dut_done);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== want[i]) begin
        errors++;
        $display("FAIL empty_rotation i=%0d got=%h exp=%h", i,
                 (i < cap.size()) ? cap[i] : 10'h3FF, want[i]);
      end
    end
  endtask

  task automatic test_mid_change();
    logic [9:0] cap[$];
    bit changed = 0;
    logic [9:0] want[3] = '{{2'd1, 8'h10}, {2'd2, 8'h10}, {2'd1, 8'h30}};
    tif.density = 8'h04;
    do_reset();
    for (int c = 0; c < 600 && cap.size() < 3; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_change c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_done && !m_yel) cap.push_back({tif.lane_state, tif.time_bcd});
      if (cap.size() == 1 && !changed && m_rem == 5) begin
        changed = 1; tif.density = 8'h0C;
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== want[i]) begin
        errors++;
        $display("FAIL mid_change_entry i=%0d got=%h exp=%h", i,
                 (i < cap.size()) ? cap[i] : 10'h3FF, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    tif.density = 8'h00;
    do_reset();
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_lane == 2 && m_yel && m_rem == 2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL async_reach got=timeout exp=lane2_yellow");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs_vec(), RST_VEC);
    end
    m_reset();
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({tif.lane_state, tif.red} !== {2'd0, 4'b1110}) begin
      errors++; $display("FAIL post_reset_red got=%h exp=%h", {tif.lane_state, tif.red}, {2'd0, 4'b1110});
    end
  endtask

  task automatic test_random();
    tif.density = 8'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) tif.density = 8'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    tif.density = 8'h00;
    m_reset();
    test_reset();
    test_full_density();
    test_bcd_borrow();
    test_skip();
    test_all_empty();
    test_mid_change();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
